// File: rtl/loteria_pkg.sv
// rtl/loteria_pkg.sv - shared types and 7-segment constants for the lottery draw and checker
package loteria_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_EMIT,
    ST_GAP,
    ST_FIN,
    ST_DONE
  } state_t;

  localparam int N_MAX_DIGITS = 8;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sorteio_loteria_dec7seg.sv
// rtl/sorteio_loteria_dec7seg.sv - digit to active-low segments, dash while not yet revealed
module dec7seg
  import loteria_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       show,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (show) seg = seg_of_digit(digit);
  end

endmodule

// File: rtl/sorteio_loteria.sv
// rtl/sorteio_loteria.sv - LFSR lottery draw, strobed digit transmitter and per-digit reveal
module sorteio_loteria
  import loteria_pkg::*;
#(
  parameter int          N_DIGITS   = 5,
  parameter int          GAP_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS  = 16'hB400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] num,
  output logic       insert,
  output logic       finish,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4
);

  localparam int IDX_W = $clog2(N_DIGITS + 1);
  localparam int CNT_W = $clog2(GAP_CYCLES + 1);

  state_t            state, state_next;
  logic [15:0]       lfsr;
  logic [3:0]        d [N_DIGITS];
  logic [N_DIGITS-1:0] rev;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  gap_cnt;
  logic              accept;
  logic [6:0]        hex_w [5];

  assign accept = (lfsr[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lfsr    <= LFSR_SEED;
      num     <= '0;
      rev     <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < N_DIGITS; i++) d[i] <= '0;
    end else begin
      state <= state_next;
      lfsr  <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rev <= '0;
            idx <= '0;
          end
        end
        // Reveal bit and num are loaded on acceptance so the HEX and num
        // are already valid during the EMIT cycle that carries insert.
        ST_DRAW: begin
          if (accept) begin
            d[idx]   <= lfsr[3:0];
            num      <= lfsr[3:0];
            rev[idx] <= 1'b1;
          end
        end
        ST_EMIT: begin
          idx     <= idx + IDX_W'(1);
          gap_cnt <= CNT_W'(GAP_CYCLES);
        end
        ST_GAP:  gap_cnt <= gap_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    insert     = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_DRAW;
      ST_DRAW: begin
        busy = 1'b1;
        if (accept) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        busy       = 1'b1;
        insert     = 1'b1;
        state_next = ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt == CNT_W'(1))
          state_next = (idx == IDX_W'(N_DIGITS)) ? ST_FIN : ST_DRAW;
      end
      ST_FIN: begin
        busy       = 1'b1;
        finish     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_DRAW;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  for (genvar k = 0; k < 5; k++) begin : g_hex
    if (k < N_DIGITS) begin : g_used
      dec7seg u_dec (
        .digit (d[k]),
        .show  (rev[k]),
        .seg   (hex_w[k])
      );
    end else begin : g_unused
      assign hex_w[k] = SEG_BLANK;
    end
  end

  assign HEX0 = hex_w[0];
  assign HEX1 = hex_w[1];
  assign HEX2 = hex_w[2];
  assign HEX3 = hex_w[3];
  assign HEX4 = hex_w[4];

endmodule
